uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter N_REQ, default 4, SHALL set the number of requester channels; the legal range is 2..8.
REQ-003 Parameter IDX_W, default 2, SHALL set the grant index width, equal to clog2(N_REQ).
REQ-004 Port clk, input, 1 bit: system clock; every flop updates on the rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port req_valid_i, input, N_REQ bits: channel k holds a byte to send.
REQ-007 Port req_data_i, input, N_REQ*8 bits: channel k's byte sits at bits [8k+7:8k].
REQ-008 Port req_ready_o, output, N_REQ bits: a one-hot, one-cycle pulse meaning channel k's byte has been captured.
REQ-009 Port grant_o, output, IDX_W bits: index of the channel that owns the transmitter.
REQ-010 Port busy_o, output, 1 bit: high in every state except IDLE.
REQ-011 Port tx_start_o, output, 1 bit: one-cycle start pulse to the UART transmitter.
REQ-012 Port tx_data_o, output, 8 bits: byte presented to the transmitter; held stable from capture until the return to IDLE.
REQ-013 Port tx_active_i, input, 1 bit: the transmitter is shifting a frame.
REQ-014 Port tx_done_i, input, 1 bit: one-cycle pulse from the transmitter at the end of the stop bit.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT_ACT and WAIT_DONE.
REQ-016 IDLE with any req_valid_i bit set SHALL, in one cycle, do all of the following:
- pick the winner, captured into grant_o;
- latch that channel's byte into tx_data_o;
- pulse req_ready_o[winner];
- go to LAUNCH.
REQ-017 Winner selection SHALL be round-robin: the first valid channel searching upward, with wrap-around, from (last_grant+1) mod N_REQ.
REQ-018 last_grant SHALL be N_REQ-1 after reset, so that channel 0 has first priority.
REQ-019 LAUNCH SHALL assert tx_start_o for exactly one cycle and then go to WAIT_ACT.
REQ-020 WAIT_ACT SHALL go to WAIT_DONE on the first cycle tx_active_i=1.
REQ-021 WAIT_DONE SHALL go to IDLE and update last_grant to grant_o on the cycle tx_done_i=1.
REQ-022 tx_done_i SHALL be ignored in IDLE, LAUNCH and WAIT_ACT.
REQ-023 Outside IDLE, req_valid_i changes SHALL have no effect, and req_ready_o SHALL stay all-zero.
REQ-024 From request to tx_start_o, latency SHALL be 2 cycles: capture in cycle N, start in cycle N+1.
REQ-025 Back-to-back transfers: the earliest next capture SHALL be the IDLE cycle after tx_done_i, with no further idle gap inserted.
REQ-026 If all channels are valid continuously, grants SHALL cycle 0,1,2,3,0,… .
REQ-027 If only a single channel is valid, that channel SHALL win every time, with no starvation penalty.
REQ-028 Requesters SHALL hold valid and data until they see ready; the arbiter does not buffer per channel.
REQ-029 An illegal state encoding SHALL return the FSM to IDLE on the next cycle.

Reset
REQ-030 While reset=1 at a clock edge, outputs SHALL be forced as follows:
- FSM = IDLE;
- req_ready_o = 0;
- grant_o = 0;
- busy_o = 0;
- tx_start_o = 0;
- tx_data_o = 8'h00;
- last_grant = N_REQ-1.
REQ-031 A reset asserted mid-frame SHALL abandon the frame; the byte is not re-sent, and the transmitter's own reset is the system's responsibility.

Configuration
REQ-032 Macro UART_TX_ARB_LOCK_EN SHALL, when defined, add an input lock_i of N_REQ bits.
- On return to IDLE from WAIT_DONE, if lock_i[grant_o]=1 and req_valid_i[grant_o]=1, that channel SHALL win again, overriding round-robin.
- last_grant SHALL be updated only when the lock is not taken.
REQ-033 Without UART_TX_ARB_LOCK_EN, the lock_i port SHALL be absent and arbitration SHALL be pure round-robin.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding and the byte width constant (8).
REQ-035 The round-robin pick SHALL be one combinational sub-module, uart_rr_pick.
- Inputs: valid vector, last_grant.
- Outputs: winner index, any_valid.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- Reset, then channel 2 valid with 8'hA5: the ready[2] pulse comes 1 cycle after valid; tx_start_o 1 cycle later with tx_data_o=8'hA5; busy_o stays high until tx_done_i.
- All 4 channels valid with distinct bytes 8'h10..8'h13: the transmitter sees 10,11,12,13,10 in order; each ready pulses exactly once per byte.
- Channel 3 just granted, then channels 0 and 3 valid: the next grant is 0, showing wrap-around.
- Reset asserted in WAIT_DONE: the next cycle shows busy_o=0, grant_o=0, and no ready pulses; after release, channel 0 has first priority.
- A stray tx_done_i pulse in IDLE and in WAIT_ACT: no state change, and no spurious start.
- With UART_TX_ARB_LOCK_EN, lock_i[1]=1, and channels 1 and 2 valid: channel 1 is granted 3 times consecutively; dropping lock_i[1] moves the next grant to 2.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: the FSM state encoding
// and the byte width used on every data path.
package uart_tx_arbiter_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_ACT  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker. Returns the first valid channel found
// searching upward, with wrap-around, starting one above the last grant.
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0] i_last_grant,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any_valid
);

  int w_dist;
  int w_best;

  // Each channel's distance past last_grant is its priority; smallest valid wins.
  always_comb begin
    o_winner    = '0;
    o_any_valid = 1'b0;
    w_best      = N_REQ;
    w_dist      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_dist = k - int'(i_last_grant) - 1;
      if (w_dist < 0) begin
        w_dist = w_dist + N_REQ;
      end
      if (i_valid[k] && (w_dist < w_best)) begin
        w_best      = w_dist;
        o_winner    = IDX_W'(k);
        o_any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte requesters onto a single UART transmitter.
// A winner is captured in IDLE, started in LAUNCH, and the arbiter then
// follows the transmitter through its active and done handshakes.
// Optional feature: define UART_TX_ARB_LOCK_EN to add lock_i, which lets the
// channel that just finished keep the transmitter for its next byte.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*BYTE_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [IDX_W-1:0]        grant_o,
  output logic                    busy_o,
  output logic                    tx_start_o,
  output logic [BYTE_W-1:0]       tx_data_o,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [N_REQ-1:0]        lock_i,
`endif
  input  logic                    tx_active_i,
  input  logic                    tx_done_i
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   w_rr_winner;
  logic               w_any_valid;
  logic [IDX_W-1:0]   w_pick;
  logic [BYTE_W-1:0]  w_byte;
  logic [N_REQ-1:0]   w_onehot;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_valid      (req_valid_i),
    .i_last_grant (r_last_grant),
    .o_winner     (w_rr_winner),
    .o_any_valid  (w_any_valid)
  );

`ifdef UART_TX_ARB_LOCK_EN
  // Set when the previous owner held its lock at the end of its frame.
  logic r_lock_take;
  logic w_lock_hit;

  // A held lock only wins if the owner is still presenting a byte.
  assign w_lock_hit = lock_i[grant_o] && req_valid_i[grant_o];
  assign w_pick     = (r_lock_take && req_valid_i[grant_o]) ? grant_o : w_rr_winner;
`else
  assign w_pick     = w_rr_winner;
`endif

  // Mux the winning channel's byte and build its one-hot ready pattern.
  always_comb begin
    w_byte   = '0;
    w_onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (IDX_W'(k) == w_pick) begin
        w_byte      = req_data_i[k*BYTE_W +: BYTE_W];
        w_onehot[k] = 1'b1;
      end
    end
  end

  // Arbitration FSM; every output is registered and pulses default low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      req_ready_o  <= '0;
      grant_o      <= '0;
      busy_o       <= 1'b0;
      tx_start_o   <= 1'b0;
      tx_data_o    <= '0;
      r_last_grant <= IDX_W'(N_REQ - 1);
`ifdef UART_TX_ARB_LOCK_EN
      r_lock_take  <= 1'b0;
`endif
    end else begin
      req_ready_o <= '0;
      tx_start_o  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            grant_o     <= w_pick;
            tx_data_o   <= w_byte;
            req_ready_o <= w_onehot;
            busy_o      <= 1'b1;
            r_state     <= ST_LAUNCH;
`ifdef UART_TX_ARB_LOCK_EN
            r_lock_take <= 1'b0;
`endif
          end
        end
        ST_LAUNCH: begin
          tx_start_o <= 1'b1;
          r_state    <= ST_WAIT_ACT;
        end
        ST_WAIT_ACT: begin
          if (tx_active_i) begin
            r_state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_done_i) begin
            r_state <= ST_IDLE;
            busy_o  <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            // A taken lock leaves the rotation pointer where it was.
            if (w_lock_hit) begin
              r_lock_take <= 1'b1;
            end else begin
              r_last_grant <= grant_o;
            end
`else
            r_last_grant <= grant_o;
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with a transaction-level reference
// model checked every cycle, a simple transmitter responder and requesters
// that hold valid/data until they see ready.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid_i = '0;
  logic [N*8-1:0] req_data_i = '0;
  logic           tx_active_i = 1'b0;
  logic           tx_done_i = 1'b0;
  logic [N-1:0]   req_ready_o;
  logic [1:0]     grant_o;
  logic           busy_o;
  logic           tx_start_o;
  logic [7:0]     tx_data_o;
`ifdef UART_TX_ARB_LOCK_EN
  logic [N-1:0]   lock_i = '0;
`endif

  uart_tx_arbiter #(.N_REQ(N), .IDX_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .tx_start_o  (tx_start_o),
    .tx_data_o   (tx_data_o),
`ifdef UART_TX_ARB_LOCK_EN
    .lock_i      (lock_i),
`endif
    .tx_active_i (tx_active_i),
    .tx_done_i   (tx_done_i)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phase: 0 no owner, 1 byte captured, 2 start issued, 3 frame running.
  int         m_phase = 0;
  int         m_last  = N - 1;
  int         m_grant = 0;
  bit         m_lock  = 1'b0;
  logic [7:0] m_data  = '0;
  logic [N-1:0] m_ready = '0;
  logic       m_start = 1'b0;
  logic       m_busy  = 1'b0;
  int         m_cyc   = 0;

  // Scan upward from the last owner, wrapping, for the next requester.
  function automatic int rr_next(input logic [N-1:0] v, input int last);
    int c;
    c = last;
    for (int s = 0; s < N; s++) begin
      c = (c + 1) % N;
      if (v[c[1:0]]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    m_cyc   = m_cyc + 1;
    m_ready = '0;
    m_start = 1'b0;
    if (reset) begin
      m_phase = 0; m_last = N - 1; m_grant = 0; m_data = '0; m_lock = 1'b0;
    end else if (m_phase == 0) begin
      if (req_valid_i != '0) begin
        w = rr_next(req_valid_i, m_last);
        if (m_lock && req_valid_i[m_grant[1:0]]) w = m_grant;
        m_lock  = 1'b0;
        m_grant = w;
        m_data  = 8'(req_data_i >> (8 * w));
        m_ready = 4'(1 << w);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_start = 1'b1;
      m_phase = 2;
    end else if (m_phase == 2) begin
      if (tx_active_i) m_phase = 3;
    end else begin
      if (tx_done_i) begin
        m_phase = 0;
`ifdef UART_TX_ARB_LOCK_EN
        if (lock_i[m_grant[1:0]] && req_valid_i[m_grant[1:0]]) m_lock = 1'b1;
        else m_last = m_grant;
`else
        m_last = m_grant;
`endif
      end
    end
    m_busy = (m_phase != 0);
  end

  // ---------------- bench state ----------------
  int         tests = 0;
  int         fails = 0;
  int         rq_cnt [N];
  logic [7:0] rq_byte [N];
  int         rcnt [N];
  int         glog [$];
  logic [7:0] blog [$];
  bit         auto_tx = 1'b1;
  int         tx_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: compare at the falling edge, then update requesters/transmitter.
  task automatic step();
    @(negedge clk);
    if (m_cyc > 0) begin
      chk("ready", 32'(req_ready_o), 32'(m_ready));
      chk("grant", 32'(grant_o), 32'(m_grant));
      chk("busy",  32'(busy_o), 32'(m_busy));
      chk("start", 32'(tx_start_o), 32'(m_start));
      chk("data",  32'(tx_data_o), 32'(m_data));
    end
    if (req_ready_o != '0) glog.push_back(int'(grant_o));
    if (tx_start_o) blog.push_back(tx_data_o);
    for (int k = 0; k < N; k++) begin
      if (req_ready_o[k]) begin
        rcnt[k]++;
        if (rq_cnt[k] > 0) rq_cnt[k]--;
      end
      req_valid_i[k]        = (rq_cnt[k] != 0);
      req_data_i[8*k +: 8]  = rq_byte[k];
    end
    tx_done_i = 1'b0;
    if (auto_tx) begin
      if (tx_start_o) tx_cnt = 1;
      else if (tx_cnt > 0) tx_cnt++;
      tx_active_i = (tx_cnt >= 2) && (tx_cnt <= 5);
      if (tx_cnt == 6) begin
        tx_done_i = 1'b1;
        tx_cnt    = 0;
      end
    end
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += rq_cnt[k];
    return s;
  endfunction

  task automatic drain(input int max, input string nm);
    int n;
    n = 0;
    while (!(busy_o == 1'b0 && req_valid_i == '0 && pending() == 0) && n < max) begin
      step();
      n++;
    end
    tests++;
    if (n >= max) begin
      fails++;
      $display("FAIL %s: no return to idle within %0d cycles", nm, max);
    end
  endtask

  task automatic clear_logs();
    glog.delete();
    blog.delete();
    for (int k = 0; k < N; k++) rcnt[k] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tx_cnt = 0; tx_active_i = 1'b0;
    step(); step();
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rq_cnt[k] = 0; rq_byte[k] = '0; rcnt[k] = 0;
    end
    // Reset state
    reset = 1'b1;
    repeat (3) step();
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_data",  32'(tx_data_o), 32'd0);
    chk("rst_start", 32'(tx_start_o), 32'd0);
    reset = 1'b0;
    step();

    // Single request on channel 2: ready one cycle after valid, start one later
    rq_byte[2] = 8'hA5; rq_cnt[2] = 1;
    step();
    step();
    chk("s1_ready", 32'(req_ready_o), 32'h4);
    chk("s1_grant", 32'(grant_o), 32'd2);
    step();
    chk("s1_start", 32'(tx_start_o), 32'd1);
    chk("s1_data",  32'(tx_data_o), 32'hA5);
    chk("s1_busy",  32'(busy_o), 32'd1);
    drain(40, "s1_drain");
    chk("s1_idle", 32'(busy_o), 32'd0);

    // All channels valid, fresh priority: bytes 10,11,12,13,10
    do_reset();
    for (int k = 0; k < N; k++) begin
      rq_byte[k] = 8'h10 + 8'(k);
      rq_cnt[k]  = (k == 0) ? 2 : 1;
    end
    drain(200, "s2_drain");
    chk("s2_nbytes", 32'(blog.size()), 32'd5);
    if (blog.size() == 5) begin
      chk("s2_b0", 32'(blog[0]), 32'h10);
      chk("s2_b1", 32'(blog[1]), 32'h11);
      chk("s2_b2", 32'(blog[2]), 32'h12);
      chk("s2_b3", 32'(blog[3]), 32'h13);
      chk("s2_b4", 32'(blog[4]), 32'h10);
    end
    chk("s2_r0", 32'(rcnt[0]), 32'd2);
    chk("s2_r1", 32'(rcnt[1]), 32'd1);
    chk("s2_r2", 32'(rcnt[2]), 32'd1);
    chk("s2_r3", 32'(rcnt[3]), 32'd1);

    // Wrap-around: channel 3 granted, then 0 and 3 valid -> 0 wins
    clear_logs();
    rq_byte[3] = 8'h33; rq_cnt[3] = 1;
    drain(60, "s3a_drain");
    rq_byte[0] = 8'h30; rq_cnt[0] = 1;
    rq_byte[3] = 8'h34; rq_cnt[3] = 1;
    drain(100, "s3b_drain");
    chk("s3_ngrants", 32'(glog.size()), 32'd3);
    if (glog.size() == 3) begin
      chk("s3_g0", 32'(glog[0]), 32'd3);
      chk("s3_g1", 32'(glog[1]), 32'd0);
      chk("s3_g2", 32'(glog[2]), 32'd3);
    end

    // Reset while a frame is running
    clear_logs();
    rq_byte[1] = 8'h51; rq_cnt[1] = 1;
    begin
      int n;
      n = 0;
      while (tx_active_i !== 1'b1 && n < 30) begin step(); n++; end
      tests++;
      if (n >= 30) begin
        fails++;
        $display("FAIL s4_active: transmitter never became active");
      end
    end
    step();
    chk("s4_pre_busy", 32'(busy_o), 32'd1);
    reset = 1'b1; tx_cnt = 0; tx_active_i = 1'b0;
    rq_byte[0] = 8'h60; rq_cnt[0] = 1;
    rq_byte[2] = 8'h62; rq_cnt[2] = 1;
    step();
    step();
    chk("s4_busy",  32'(busy_o), 32'd0);
    chk("s4_grant", 32'(grant_o), 32'd0);
    chk("s4_ready", 32'(req_ready_o), 32'd0);
    step();
    chk("s4_ready2", 32'(req_ready_o), 32'd0);
    reset = 1'b0;
    clear_logs();
    drain(120, "s4_drain");
    chk("s4_ngrants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      chk("s4_g0", 32'(glog[0]), 32'd0);
      chk("s4_g1", 32'(glog[1]), 32'd2);
    end
    chk("s4_nbytes", 32'(blog.size()), 32'd2);

    // Stray tx_done in IDLE and in WAIT_ACT
    auto_tx = 1'b0; tx_active_i = 1'b0;
    clear_logs();
    step();
    tx_done_i = 1'b1;
    step();
    step();
    chk("s5_idle_busy",  32'(busy_o), 32'd0);
    chk("s5_idle_start", 32'(tx_start_o), 32'd0);
    rq_byte[1] = 8'h77; rq_cnt[1] = 1;
    step();
    step();
    chk("s5_ready", 32'(req_ready_o), 32'h2);
    step();
    chk("s5_start", 32'(tx_start_o), 32'd1);
    tx_done_i = 1'b1;
    step();
    step();
    chk("s5_wa_busy",  32'(busy_o), 32'd1);
    chk("s5_wa_start", 32'(tx_start_o), 32'd0);
    tx_active_i = 1'b1;
    step();
    tx_active_i = 1'b0;
    step();
    chk("s5_wd_busy", 32'(busy_o), 32'd1);
    tx_done_i = 1'b1;
    step();
    step();
    chk("s5_end_busy", 32'(busy_o), 32'd0);
    chk("s5_nbytes", 32'(blog.size()), 32'd1);
    auto_tx = 1'b1;

`ifdef UART_TX_ARB_LOCK_EN
    // Lock keeps channel 1 for three frames; dropping it lets channel 2 in
    do_reset();
    lock_i = 4'b0010;
    rq_byte[1] = 8'h11; rq_cnt[1] = 4;
    rq_byte[2] = 8'h22; rq_cnt[2] = 1;
    begin
      int n;
      n = 0;
      while (!(busy_o == 1'b0 && req_valid_i == '0 && pending() == 0) && n < 300) begin
        step();
        if (glog.size() >= 3) lock_i = '0;
        n++;
      end
      tests++;
      if (n >= 300) begin
        fails++;
        $display("FAIL s6_drain: no return to idle within 300 cycles");
      end
    end
    chk("s6_ngrants", 32'(glog.size()), 32'd5);
    if (glog.size() == 5) begin
      chk("s6_g0", 32'(glog[0]), 32'd1);
      chk("s6_g1", 32'(glog[1]), 32'd1);
      chk("s6_g2", 32'(glog[2]), 32'd1);
      chk("s6_g3", 32'(glog[3]), 32'd2);
      chk("s6_g4", 32'(glog[4]), 32'd1);
    end
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
